// File: rtl/dual_issue_pkg.sv
// Shared types and constants for the dual-issue grant picker.
package dual_issue_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  localparam int unsigned MAX_GNT_PER_CYCLE = 2;
  localparam int unsigned GNT_CNT_W         = $clog2(MAX_GNT_PER_CYCLE + 1);

endpackage

// File: rtl/lsb_onehot_pick.sv
// Ripple priority picker: one-hot isolation of the lowest set bit.
//   req  : input vector
//   pick : one-hot lowest set bit of req, zero when req is zero
module lsb_onehot_pick #(
  parameter int unsigned WIDTH = 12
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] pick
);

  // Running "any lower bit set" term blocks every higher bit.
  always_comb begin
    logic seen;
    pick = '0;
    seen = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      pick[i] = req[i] & ~seen;
      seen    = seen | req[i];
    end
  end

endmodule

// File: rtl/dual_issue_picker.sv
// Accepts a request vector and drains it, issuing up to two one-hot grants
// (lowest and second-lowest pending bits) per grant handshake.
//   clk, reset_n                       : clock, async active-low reset
//   req_valid_i/req_ready_o/req_vec_i  : request vector handshake
//   gnt_valid_o/gnt_ready_i            : grant pair handshake
//   gnt0_o, gnt1_o                     : one-hot grants (zero when absent)
//   gnt_cnt_o                          : grants in the current pair (0..2)
//   pending_cnt_o                      : popcount of the pending register
//   done_o                             : one-cycle pulse once fully drained
module dual_issue_picker
  import dual_issue_pkg::*;
#(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [WIDTH-1:0]     req_vec_i,
  output logic                 gnt_valid_o,
  input  logic                 gnt_ready_i,
  output logic [WIDTH-1:0]     gnt0_o,
  output logic [WIDTH-1:0]     gnt1_o,
  output logic [GNT_CNT_W-1:0] gnt_cnt_o,
  output logic [CNT_W-1:0]     pending_cnt_o,
  output logic                 done_o
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             done_d;
  logic [WIDTH-1:0] pick0, pick1;
  logic [WIDTH-1:0] pending_rest;

  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      acc = acc + CNT_W'(v[i]);
    end
    return acc;
  endfunction

  // Second grant is the lowest bit left after removing the first.
  assign pending_rest = pending_q & ~pick0;

  lsb_onehot_pick #(.WIDTH(WIDTH)) u_pick0 (
    .req  (pending_q),
    .pick (pick0)
  );

  lsb_onehot_pick #(.WIDTH(WIDTH)) u_pick1 (
    .req  (pending_rest),
    .pick (pick1)
  );

  // State, pending vector and done pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      done_o    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      done_o    <= done_d;
    end
  end

  // Next-state and handshake/grant outputs.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    done_d      = 1'b0;
    req_ready_o = 1'b0;
    gnt_valid_o = 1'b0;
    gnt0_o      = '0;
    gnt1_o      = '0;
    gnt_cnt_o   = '0;

    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        // A zero vector completes the handshake but is dropped.
        if (req_valid_i && (req_vec_i != '0)) begin
          pending_d = req_vec_i;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        gnt_valid_o = 1'b1;
        gnt0_o      = pick0;
        gnt1_o      = pick1;
        gnt_cnt_o   = GNT_CNT_W'(pick0 != '0) + GNT_CNT_W'(pick1 != '0);
        if (gnt_ready_i) begin
          pending_d = pending_q & ~(pick0 | pick1);
          if (pending_d == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pending_cnt_o = popcount(pending_q);

endmodule

// File: tb/tb_dual_issue_picker.sv
// Directed, table-driven bench for dual_issue_picker at WIDTH=8.
module tb_dual_issue_picker;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = $clog2(W + 1);

  logic          clk;
  logic          reset_n;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [W-1:0]  req_vec_i;
  logic          gnt_valid_o;
  logic          gnt_ready_i;
  logic [W-1:0]  gnt0_o;
  logic [W-1:0]  gnt1_o;
  logic [1:0]    gnt_cnt_o;
  logic [CW-1:0] pending_cnt_o;
  logic          done_o;

  int checks;
  int failures;

  dual_issue_picker #(.WIDTH(W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_vec_i     (req_vec_i),
    .gnt_valid_o   (gnt_valid_o),
    .gnt_ready_i   (gnt_ready_i),
    .gnt0_o        (gnt0_o),
    .gnt1_o        (gnt1_o),
    .gnt_cnt_o     (gnt_cnt_o),
    .pending_cnt_o (pending_cnt_o),
    .done_o        (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Up to four grant pairs per vector; pair p lives at bit offset p*8 / p*2 / p*4.
  typedef struct packed {
    logic [7:0]  vec;
    logic [2:0]  n_pairs;
    logic [31:0] g0s;
    logic [31:0] g1s;
    logic [7:0]  cnts;
    logic [15:0] pcs;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit past the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".ready"},  32'(req_ready_o),   32'd1);
    chk({tag, ".gvalid"}, 32'(gnt_valid_o),   32'd0);
    chk({tag, ".g0"},     32'(gnt0_o),        32'd0);
    chk({tag, ".g1"},     32'(gnt1_o),        32'd0);
    chk({tag, ".cnt"},    32'(gnt_cnt_o),     32'd0);
    chk({tag, ".pcnt"},   32'(pending_cnt_o), 32'd0);
  endtask

  task automatic chk_pair(input string tag, input logic [7:0] g0, input logic [7:0] g1,
                          input logic [1:0] cnt, input logic [3:0] pc);
    chk({tag, ".gvalid"}, 32'(gnt_valid_o),   32'd1);
    chk({tag, ".ready"},  32'(req_ready_o),   32'd0);
    chk({tag, ".g0"},     32'(gnt0_o),        32'(g0));
    chk({tag, ".g1"},     32'(gnt1_o),        32'(g1));
    chk({tag, ".cnt"},    32'(gnt_cnt_o),     32'(cnt));
    chk({tag, ".pcnt"},   32'(pending_cnt_o), 32'(pc));
    chk({tag, ".done"},   32'(done_o),        32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks      = 0;
    failures    = 0;
    reset_n     = 1'b0;
    req_valid_i = 1'b0;
    req_vec_i   = '0;
    gnt_ready_i = 1'b0;

    tbl[0] = '{vec: 8'hB6, n_pairs: 3'd3,
               g0s: {8'h00, 8'h80, 8'h10, 8'h02}, g1s: {8'h00, 8'h00, 8'h20, 8'h04},
               cnts: {2'd0, 2'd1, 2'd2, 2'd2}, pcs: {4'd0, 4'd1, 4'd3, 4'd5}};
    tbl[1] = '{vec: 8'h80, n_pairs: 3'd1,
               g0s: {8'h00, 8'h00, 8'h00, 8'h80}, g1s: 32'h0,
               cnts: {2'd0, 2'd0, 2'd0, 2'd1}, pcs: {4'd0, 4'd0, 4'd0, 4'd1}};
    tbl[2] = '{vec: 8'h03, n_pairs: 3'd1,
               g0s: {8'h00, 8'h00, 8'h00, 8'h01}, g1s: {8'h00, 8'h00, 8'h00, 8'h02},
               cnts: {2'd0, 2'd0, 2'd0, 2'd2}, pcs: {4'd0, 4'd0, 4'd0, 4'd2}};
    tbl[3] = '{vec: 8'hFF, n_pairs: 3'd4,
               g0s: {8'h40, 8'h10, 8'h04, 8'h01}, g1s: {8'h80, 8'h20, 8'h08, 8'h02},
               cnts: {2'd2, 2'd2, 2'd2, 2'd2}, pcs: {4'd2, 4'd4, 4'd6, 4'd8}};
    tbl[4] = '{vec: 8'h55, n_pairs: 3'd2,
               g0s: {8'h00, 8'h00, 8'h10, 8'h01}, g1s: {8'h00, 8'h00, 8'h40, 8'h04},
               cnts: {2'd0, 2'd0, 2'd2, 2'd2}, pcs: {4'd0, 4'd0, 4'd2, 4'd4}};
    tbl[5] = '{vec: 8'h01, n_pairs: 3'd1,
               g0s: {8'h00, 8'h00, 8'h00, 8'h01}, g1s: 32'h0,
               cnts: {2'd0, 2'd0, 2'd0, 2'd1}, pcs: {4'd0, 4'd0, 4'd0, 4'd1}};

    // Reset state.
    #12;
    chk_idle("reset");
    chk("reset.done", 32'(done_o), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // Table: each vector drained with the sink always ready.
    gnt_ready_i = 1'b1;
    for (int t = 0; t < 6; t++) begin
      string tag;
      tag = $sformatf("vec%0d", t);
      chk({tag, ".ready_pre"}, 32'(req_ready_o), 32'd1);
      req_valid_i = 1'b1;
      req_vec_i   = tbl[t].vec;
      step();
      req_valid_i = 1'b0;
      req_vec_i   = '0;
      for (int p = 0; p < int'(tbl[t].n_pairs); p++) begin
        chk_pair($sformatf("%s.p%0d", tag, p), tbl[t].g0s[p*8 +: 8], tbl[t].g1s[p*8 +: 8],
                 tbl[t].cnts[p*2 +: 2], tbl[t].pcs[p*4 +: 4]);
        step();
      end
      chk({tag, ".done"}, 32'(done_o), 32'd1);
      chk_idle({tag, ".end"});
      step();
      chk({tag, ".done_clr"}, 32'(done_o), 32'd0);
    end

    // Zero vector: handshake completes, nothing issued, no done pulse.
    req_valid_i = 1'b1;
    req_vec_i   = 8'h00;
    step();
    req_valid_i = 1'b0;
    chk_idle("zero");
    chk("zero.done", 32'(done_o), 32'd0);
    step();
    chk("zero.done2", 32'(done_o), 32'd0);

    // All ones with a 5-cycle stall: grants and count must hold.
    gnt_ready_i = 1'b0;
    req_valid_i = 1'b1;
    req_vec_i   = 8'hFF;
    step();
    req_valid_i = 1'b0;
    for (int s = 0; s < 5; s++) begin
      chk_pair($sformatf("stall%0d", s), 8'h01, 8'h02, 2'd2, 4'd8);
      step();
    end
    gnt_ready_i = 1'b1;
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("ff.pcnt%0d", p), 32'(pending_cnt_o), 32'(8 - 2 * p));
      chk($sformatf("ff.gv%0d", p),   32'(gnt_valid_o),   32'd1);
      step();
    end
    chk("ff.done", 32'(done_o), 32'd1);
    chk_idle("ff.end");
    step();

    // Reset mid-drain: outputs drop immediately, no done afterwards.
    req_valid_i = 1'b1;
    req_vec_i   = 8'hF0;
    step();
    req_valid_i = 1'b0;
    chk_pair("rst.p0", 8'h10, 8'h20, 2'd2, 4'd4);
    step();
    chk_pair("rst.p1", 8'h40, 8'h80, 2'd2, 4'd2);
    #2;
    reset_n = 1'b0;
    #1;
    chk_idle("rst.async");
    chk("rst.done", 32'(done_o), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("rst.nodone%0d", c), 32'(done_o), 32'd0);
      chk($sformatf("rst.ready%0d", c),  32'(req_ready_o), 32'd1);
    end

    // Upstream holds 8'h03 during a drain of 8'h0F; accepted only after it ends.
    req_valid_i = 1'b1;
    req_vec_i   = 8'h0F;
    step();
    req_vec_i   = 8'h03;
    chk_pair("ovl.p0", 8'h01, 8'h02, 2'd2, 4'd4);
    step();
    chk_pair("ovl.p1", 8'h04, 8'h08, 2'd2, 4'd2);
    step();
    chk("ovl.done", 32'(done_o), 32'd1);
    chk("ovl.ready", 32'(req_ready_o), 32'd1);
    chk("ovl.gvalid", 32'(gnt_valid_o), 32'd0);
    step();
    req_valid_i = 1'b0;
    chk_pair("ovl.new", 8'h01, 8'h02, 2'd2, 4'd2);
    step();
    chk("ovl.done2", 32'(done_o), 32'd1);
    chk_idle("ovl.end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dual_issue_picker.md
Name: dual_issue_picker

Overview:
- Consumes a WIDTH-bit request vector through a valid/ready handshake and drains it over successive cycles, issuing up to two one-hot grants per output handshake.
- Grant 0 is the lowest set bit; grant 1 is the second-lowest set bit.
- Sits downstream of the request collectors. Feeds the dual-ported execution slots, which accept one grant pair per handshake.

Parameters:
- WIDTH, 12, request vector width; legal range 2..64.
- CNT_W, $clog2(WIDTH+1), width of the pending-bit count output (derived; do not override).

Ports:
- clk  input  1  clock; all flops rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- req_valid_i  input  1  upstream vector valid.
- req_ready_o  output  1  picker can accept a vector.
- req_vec_i  input  WIDTH  request vector; sampled on req handshake.
- gnt_valid_o  output  1  grant pair valid.
- gnt_ready_i  input  1  downstream accepts grant pair.
- gnt0_o  output  WIDTH  one-hot lowest pending bit; zero if none.
- gnt1_o  output  WIDTH  one-hot second-lowest pending bit; zero if fewer than 2 pending.
- gnt_cnt_o  output  2  number of grants in pair: 0, 1 or 2.
- pending_cnt_o  output  CNT_W  popcount of the pending register.
- done_o  output  1  one-cycle pulse after the vector is fully drained.

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert):
  - state=IDLE, pending=0, done_o=0.
  - Outputs are therefore req_ready_o=1, gnt_valid_o=0, gnt0_o=gnt1_o=0, gnt_cnt_o=0, pending_cnt_o=0.
- State machine (two states):
  - IDLE:
    - req_ready_o=1.
    - On req_valid_i&&req_ready_o with req_vec_i!=0: pending<=req_vec_i, go to ISSUE.
    - With req_vec_i==0: the handshake completes, the vector is dropped, state stays IDLE and done_o does not pulse.
  - ISSUE:
    - req_ready_o=0.
    - gnt_valid_o=1 combinationally from state.
    - On gnt_valid_o&&gnt_ready_i: pending<=pending & ~(gnt0_o|gnt1_o).
    - If the next pending value is 0, go to IDLE and pulse done_o in the following cycle, registered and coincident with the return to IDLE.
- Grant derivation, combinational from the pending register:
  - gnt0_o is the one-hot lowest set bit of pending.
  - gnt1_o is the one-hot lowest set bit of (pending & ~gnt0_o).
  - gnt_cnt_o = (gnt0_o!=0) + (gnt1_o!=0).
  - In IDLE all three outputs are forced to 0.
- Latency:
  - A vector accepted in cycle N gives gnt_valid_o=1 in cycle N+1.
  - A vector with K set bits needs ceil(K/2) grant handshakes.
  - req_ready_o rises in the cycle after the last grant handshake.
- Stability: while gnt_valid_o=1 and gnt_ready_i=0, gnt0_o, gnt1_o, gnt_cnt_o and pending_cnt_o hold constant (pending changes only on handshake).
- Boundary conditions:
  - Single-bit vector: one handshake with gnt_cnt_o=1 and gnt1_o=0.
  - Odd K: the final pair has gnt_cnt_o=1.
  - Bit WIDTH-1 alone is still granted on gnt0_o.
  - All ones: exactly WIDTH/2 handshakes (ceil for odd WIDTH).
  - No back-to-back overlap: a new vector is never accepted in the same cycle as the last grant.
  - req_valid_i while in ISSUE is ignored (ready low); upstream holds the vector.
  - reset_n asserted mid-drain: pending clears immediately, gnt_valid_o drops asynchronously, no done_o pulse.
- Invariant: gnt0_o & gnt1_o == 0, and both are subsets of pending.

Decomposition:
- Package dual_issue_pkg:
  - state_t enum {IDLE, ISSUE}.
  - localparam MAX_GNT_PER_CYCLE=2.
- Sub-module lsb_onehot_pick #(WIDTH):
  - Pure combinational ripple priority: out[0]=in[0], out[i]=in[i]&~|out[i-1:0].
  - Instantiated twice: on pending, and on pending masked by the first grant.
- Popcount for pending_cnt_o is a local function in the top module.

Test Plan:
- WIDTH=8, reset, then req_vec_i=8'b1011_0110 with gnt_ready_i=1:
  - Pair 1: gnt0=0000_0010, gnt1=0000_0100, cnt=2.
  - Pair 2: gnt0=0001_0000, gnt1=0010_0000, cnt=2.
  - Pair 3: gnt0=1000_0000, gnt1=0, cnt=1.
  - done_o pulses one cycle after pair 3; req_ready_o returns high.
- req_vec_i=8'h00 handshake: state stays IDLE, gnt_valid_o stays 0, no done_o pulse.
- req_vec_i=8'hFF with gnt_ready_i held 0 for 5 cycles then 1:
  - Outputs stable at 0000_0001/0000_0010 and pending_cnt_o=8 during the stall.
  - Then 4 handshakes, pending_cnt_o stepping 8,6,4,2.
- req_vec_i=8'h80: a single pair with gnt0=1000_0000, cnt=1; done_o follows.
- Load 8'hF0, complete one handshake, assert reset_n=0 mid-cycle:
  - gnt_valid_o=0 and pending_cnt_o=0 immediately.
  - After release, req_ready_o=1 and done_o is never pulsed.
- Hold req_valid_i=1 with a new vector 8'h03 during an ISSUE drain:
  - Not accepted until the cycle after the last grant handshake.
  - Then issues gnt0=01, gnt1=02 in one pair.
